frame_unpack: RTL
=================

// Module: frame_unpack
// PURPOSE
//  Receive-side counterpart of the frame packer. Consumes the serial bit stream produced
//  by the packer: a 32-bit preamble followed by a fixed-length payload.
//  Hunts for the preamble with a sliding correlator, then regroups the payload bits
//  MSB-first into bytes. Bytes are delivered through a valid/ready handshake to the
//  byte-wide consumer. Marks each frame's first and last bytes and counts frames.
// PARAMETERS
//  SIZE_BIT_PACK   1976          total frame length in bits, preamble included
//  SIZE_PREAMBLE   32            preamble length in bits
//  PREAMBLE        32'hCF80AA31  preamble pattern; first bit on the line = MSB
//  SIZE_OUTPUT_BIT 8             output word width
//  MAX_ERR         0             max Hamming distance accepted as a preamble hit (0..SIZE_PREAMBLE/4)
//  LENGTH_PAYLOAD  (SIZE_BIT_PACK-SIZE_PREAMBLE)/SIZE_OUTPUT_BIT = 243   payload words per frame (derived)
// PORTS
//  i_clk          in   1   clock, all logic on rising edge
//  i_reset        in   1   reset, asynchronous assert, active-low
//  i_data         in   1   serial input bit
//  i_valid_input  in   1   i_data is valid; bit accepted when i_valid_input && o_ready
//  o_ready        out  1   block can accept a bit this cycle
//  o_data         out  8   payload byte; first received bit of the byte is o_data[7]
//  o_valid        out  1   o_data holds an undelivered byte
//  i_ready_output in   1   consumer takes byte when o_valid && i_ready_output
//  o_sof          out  1   qualifies o_data as payload byte 0 of a frame
//  o_eof          out  1   qualifies o_data as the last payload byte (index 242)
//  o_lock         out  1   high while in PAYLOAD state
//  o_frame_cnt    out  16  count of completed frames; wraps 0xFFFF->0
// BEHAVIOUR
//  Reset (i_reset=0, async): state=SEARCH. Shift reg, fill counter, bit/byte counters = 0.
//   o_data=0, o_valid=0, o_sof=0, o_eof=0, o_lock=0, o_frame_cnt=0.
//  o_ready is combinational:
//   SEARCH: 1.
//   PAYLOAD: ~o_valid | i_ready_output.
//   The single output register is never overwritten before delivery.
//  SEARCH:
//   - Each accepted bit shifts into a 32-bit register at the LSB; the oldest bit is at the MSB.
//   - A fill counter saturates at 32.
//   - Hit = fill==32 after the shift AND popcount(shift ^ PREAMBLE) <= MAX_ERR.
//     Evaluated on the updated register, so the hit is known in the cycle the 32nd preamble bit is accepted.
//   - On a hit: state->PAYLOAD next cycle; bit_cnt=0, byte_cnt=0.
//   - The correlator slides one bit at a time. A partial match that fails does not discard
//     bits, e.g. CF CF 80 AA 31 still hits on the second CF.
//  PAYLOAD:
//   - Each accepted bit goes into the byte accumulator MSB-first; bit_cnt increments.
//   - On the 8th bit, the completed byte loads o_data in the same edge, and o_valid=1 next cycle.
//     o_sof=(byte_cnt==0), o_eof=(byte_cnt==242). byte_cnt increments.
//   - Latency: 8th bit accepted at edge N -> o_valid high after edge N.
//   - Delivery and a new byte completing on the same edge is legal. The register reloads and o_valid stays 1.
//   - When byte 242 loads:
//       state->SEARCH; o_frame_cnt += 1; shift reg and fill counter cleared.
//       The pending byte still delivers normally while SEARCH runs.
//       The next frame's preamble needs 32 fresh bits.
//  Delivery (o_valid && i_ready_output) with no new byte: o_valid, o_sof, o_eof -> 0.
//  o_data holds its value while o_valid=0.
//  No abort inside a frame: the payload is taken blindly once locked.
//  i_valid_input=0 cycles stall all counters; no timeout.
//  Reset mid-frame: everything returns to reset values immediately. A partial frame is
//   discarded and not counted.
// TESTING
//  1 Reset: hold i_reset=0 for 3 clk -> o_valid=0, o_lock=0, o_frame_cnt=0, o_ready=1.
//  2 Clean frame: bits of CF80AA31, then bytes 0x00..0xF2 MSB-first, 1 bit/2 clk, i_ready_output=1
//    -> 243 bytes 0x00..0xF2 in order; o_sof on 0x00 only; o_eof on 0xF2 only; o_frame_cnt=1.
//  3 Sliding search: 37 random bits + 0xCF + full frame -> exactly the same 243 bytes; no false lock before.
//  4 Backpressure: bit every clk, i_ready_output=0 for 20 clk mid-payload
//    -> o_ready falls after the first pending byte; no byte lost or duplicated.
//  5 Tolerance: MAX_ERR=0 with 1 flipped preamble bit -> no lock, o_frame_cnt=0.
//    MAX_ERR=2 with 2 flipped bits -> lock, frame delivered.
//  6 Reset mid-payload after byte 100, then a full clean frame -> bytes restart at 0x00 with o_sof;
//    o_frame_cnt=1. Also two back-to-back frames -> 486 bytes, o_frame_cnt=2.

Source files
------------

// File: rtl/frame_unpack_if.sv
// Handshake bundle for frame_unpack: serial bit input, byte output and status.
// The slave modport is the unpacker; the master modport is the surrounding logic.
interface frame_unpack_if #(
    parameter int unsigned SIZE_OUTPUT_BIT = 8
);
    logic                       i_data;
    logic                       i_valid_input;
    logic                       o_ready;
    logic [SIZE_OUTPUT_BIT-1:0] o_data;
    logic                       o_valid;
    logic                       i_ready_output;
    logic                       o_sof;
    logic                       o_eof;
    logic                       o_lock;
    logic [15:0]                o_frame_cnt;

    modport slave (
        input  i_data, i_valid_input, i_ready_output,
        output o_ready, o_data, o_valid, o_sof, o_eof, o_lock, o_frame_cnt
    );

    modport master (
        output i_data, i_valid_input, i_ready_output,
        input  o_ready, o_data, o_valid, o_sof, o_eof, o_lock, o_frame_cnt
    );
endinterface

// File: rtl/frame_unpack.sv
// Serial frame receiver: sliding preamble correlator followed by MSB-first byte regrouping
// of a fixed-length payload, delivered over a single-entry valid/ready output register.
module frame_unpack #(
    parameter int unsigned               SIZE_BIT_PACK   = 1976,
    parameter int unsigned               SIZE_PREAMBLE   = 32,
    parameter logic [SIZE_PREAMBLE-1:0]  PREAMBLE        = 32'hCF80AA31,
    parameter int unsigned               SIZE_OUTPUT_BIT = 8,
    parameter int unsigned               MAX_ERR         = 0
) (
    input  logic            i_clk,
    input  logic            i_reset,
    frame_unpack_if.slave   bus
);
    localparam int unsigned LENGTH_PAYLOAD = (SIZE_BIT_PACK - SIZE_PREAMBLE) / SIZE_OUTPUT_BIT;
    localparam int unsigned CNT_W          = $clog2(SIZE_PREAMBLE + 1);
    localparam int unsigned BIT_W          = $clog2(SIZE_OUTPUT_BIT);
    localparam int unsigned BYTE_W         = $clog2(LENGTH_PAYLOAD);

    localparam logic [CNT_W-1:0]  FILL_FULL = CNT_W'(SIZE_PREAMBLE);
    localparam logic [CNT_W-1:0]  ERR_LIMIT = CNT_W'(MAX_ERR);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(SIZE_OUTPUT_BIT - 1);
    localparam logic [BYTE_W-1:0] BYTE_LAST = BYTE_W'(LENGTH_PAYLOAD - 1);

    typedef enum logic {StSearch, StPayload} state_t;

    state_t                       r_state;
    logic [SIZE_PREAMBLE-1:0]     r_shift;
    logic [CNT_W-1:0]             r_fill;
    logic [SIZE_OUTPUT_BIT-2:0]   r_acc;
    logic [BIT_W-1:0]             r_bit_cnt;
    logic [BYTE_W-1:0]            r_byte_cnt;
    logic [SIZE_OUTPUT_BIT-1:0]   r_data;
    logic                         r_valid;
    logic                         r_sof;
    logic                         r_eof;
    logic [15:0]                  r_frame_cnt;

    logic                         w_ready;
    logic                         w_accept;
    logic                         w_deliver;
    logic [SIZE_PREAMBLE-1:0]     w_shift_nxt;
    logic [SIZE_PREAMBLE-1:0]     w_diff;
    logic [CNT_W-1:0]             w_fill_nxt;
    logic [CNT_W-1:0]             w_dist;
    logic                         w_hit;
    logic [SIZE_OUTPUT_BIT-1:0]   w_byte_nxt;

    // Search always accepts; in payload a bit is taken only if the output slot is free or draining.
    assign w_ready     = (r_state == StSearch) | ~r_valid | bus.i_ready_output;
    assign w_accept    = bus.i_valid_input & w_ready;
    assign w_deliver   = r_valid & bus.i_ready_output;
    assign w_shift_nxt = {r_shift[SIZE_PREAMBLE-2:0], bus.i_data};
    assign w_diff      = w_shift_nxt ^ PREAMBLE;
    assign w_fill_nxt  = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + 1'b1;
    assign w_byte_nxt  = {r_acc, bus.i_data};

    always_comb begin
        w_dist = '0;
        for (int i = 0; i < SIZE_PREAMBLE; i++) begin
            w_dist = w_dist + CNT_W'(w_diff[i]);
        end
    end

    assign w_hit = (w_fill_nxt == FILL_FULL) && (w_dist <= ERR_LIMIT);

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= StSearch;
            r_shift     <= '0;
            r_fill      <= '0;
            r_acc       <= '0;
            r_bit_cnt   <= '0;
            r_byte_cnt  <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_sof       <= 1'b0;
            r_eof       <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            // A byte completing on the same edge overrides this clear below.
            if (w_deliver) begin
                r_valid <= 1'b0;
                r_sof   <= 1'b0;
                r_eof   <= 1'b0;
            end
            unique case (r_state)
                StSearch: begin
                    if (w_accept) begin
                        r_shift <= w_shift_nxt;
                        r_fill  <= w_fill_nxt;
                        if (w_hit) begin
                            r_state    <= StPayload;
                            r_bit_cnt  <= '0;
                            r_byte_cnt <= '0;
                        end
                    end
                end
                StPayload: begin
                    if (w_accept) begin
                        r_acc     <= w_byte_nxt[SIZE_OUTPUT_BIT-2:0];
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == BIT_LAST) begin
                            r_bit_cnt  <= '0;
                            r_data     <= w_byte_nxt;
                            r_valid    <= 1'b1;
                            r_sof      <= (r_byte_cnt == '0);
                            r_eof      <= (r_byte_cnt == BYTE_LAST);
                            r_byte_cnt <= r_byte_cnt + 1'b1;
                            // Next preamble must be built from fresh bits only.
                            if (r_byte_cnt == BYTE_LAST) begin
                                r_state     <= StSearch;
                                r_frame_cnt <= r_frame_cnt + 1'b1;
                                r_shift     <= '0;
                                r_fill      <= '0;
                                r_byte_cnt  <= '0;
                            end
                        end
                    end
                end
                default: r_state <= StSearch;
            endcase
        end
    end

    assign bus.o_ready     = w_ready;
    assign bus.o_data      = r_data;
    assign bus.o_valid     = r_valid;
    assign bus.o_sof       = r_sof;
    assign bus.o_eof       = r_eof;
    assign bus.o_lock      = (r_state == StPayload);
    assign bus.o_frame_cnt = r_frame_cnt;
endmodule
